// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_decoder
// Purpose  : Receive-side VGA timing decoder. Measures line/frame periods from
//            the sync pins, locks onto a stable raster, rebuilds X/Y counters
//            and display-enable, and captures one probe pixel per frame.
// Options  : define VGA_DEC_STATS_EN to add frame_cnt / err_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_decoder #(
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int H_SYNC_START    = 656,
  parameter int V_SYNC_START    = 490,
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [2:0] pix_in,
  input  logic [9:0] probe_x,
  input  logic [9:0] probe_y,
  output logic       locked,
  output logic       lock_lost,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       de_out,
  output logic [9:0] h_total,
  output logic [9:0] v_total,
  output logic [2:0] probe_pix,
  output logic       probe_valid
`ifdef VGA_DEC_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
`endif
);

  localparam logic       c_sync_idle   = (SYNC_ACTIVE_LOW != 0);
  localparam logic [9:0] c_h_load      = 10'(H_SYNC_START);
  localparam logic [9:0] c_v_load      = 10'(V_SYNC_START);
  localparam logic [9:0] c_h_active    = 10'(H_ACTIVE);
  localparam logic [9:0] c_v_active    = 10'(V_ACTIVE);
  localparam logic [3:0] c_lock_frames = 4'(LOCK_FRAMES);
  localparam logic [9:0] c_cnt_max     = 10'd1023;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Input stage
  logic       hs_q, hs_prev_q, vs_q, vs_prev_q;
  logic [2:0] pix_q, pix_dly_q;

  // Measurement / FSM state
  state_t     state_q, state_d;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic [9:0] last_period_q, last_period_d;
  logic       frame_bad_q, frame_bad_d;
  logic       ref_valid_q, ref_valid_d;
  logic [3:0] match_q, match_d;
  logic [9:0] h_total_q, h_total_d;
  logic [9:0] v_total_q, v_total_d;
  logic       lock_lost_q, lock_lost_d;

  // Raster reconstruction and outputs
  logic [9:0] x_cnt_q, x_cnt_d;
  logic [9:0] y_cnt_q, y_cnt_d;
  logic [9:0] x_pos_q, x_pos_d;
  logic [9:0] y_pos_q, y_pos_d;
  logic       de_q, de_d;
  logic [2:0] probe_pix_q, probe_pix_d;
  logic       probe_valid_q, probe_valid_d;

  // Combinational helpers
  logic       w_hs_edge, w_vs_edge;
  logic [9:0] w_period, w_lines, w_last_period;
  logic       w_line_bad, w_frame_bad, w_x_wrap, w_lock_next, w_probe_hit;

  // XOR with the idle level turns either polarity into an active-high flag
  assign w_hs_edge = (hs_q ^ c_sync_idle) & ~(hs_prev_q ^ c_sync_idle);
  assign w_vs_edge = (vs_q ^ c_sync_idle) & ~(vs_prev_q ^ c_sync_idle);

  // A saturated counter wraps the period to a meaningless value, so it is
  // flagged bad on its own rather than relying on the compare.
  assign w_period      = hcnt_q + 10'd1;
  assign w_line_bad    = w_hs_edge && ((hcnt_q == c_cnt_max) || (w_period != h_total_q));
  // Line accounting comes before frame accounting on coincident edges
  assign w_lines       = (w_hs_edge && (vcnt_q != c_cnt_max)) ? vcnt_q + 10'd1 : vcnt_q;
  assign w_last_period = w_hs_edge ? w_period : last_period_q;
  assign w_frame_bad   = frame_bad_q || w_line_bad || (w_lines != v_total_q);

  // Register the pins; the second pixel stage lines pixel data up with x_pos/y_pos
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q      <= c_sync_idle;
      hs_prev_q <= c_sync_idle;
      vs_q      <= c_sync_idle;
      vs_prev_q <= c_sync_idle;
      pix_q     <= 3'd0;
      pix_dly_q <= 3'd0;
    end else begin
      hs_q      <= hsync_in;
      hs_prev_q <= hs_q;
      vs_q      <= vsync_in;
      vs_prev_q <= vs_q;
      pix_q     <= pix_in;
      pix_dly_q <= pix_q;
    end
  end

  // Period counters and lock FSM next-state
  always_comb begin
    hcnt_d        = w_hs_edge ? 10'd0 : ((hcnt_q == c_cnt_max) ? hcnt_q : hcnt_q + 10'd1);
    vcnt_d        = w_vs_edge ? 10'd0 : w_lines;
    last_period_d = w_last_period;
    frame_bad_d   = w_vs_edge ? 1'b0 : (frame_bad_q || w_line_bad);
    state_d       = state_q;
    ref_valid_d   = ref_valid_q;
    match_d       = match_q;
    h_total_d     = h_total_q;
    v_total_d     = v_total_q;
    lock_lost_d   = 1'b0;

    case (state_q)
      ST_SEARCH: begin
        ref_valid_d = 1'b0;
        match_d     = 4'd0;
        if (w_vs_edge) begin
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (w_vs_edge) begin
          // First full frame, or any disagreement, becomes the new reference
          if (!ref_valid_q || w_frame_bad) begin
            h_total_d   = w_last_period;
            v_total_d   = w_lines;
            match_d     = 4'd1;
            ref_valid_d = 1'b1;
          end else begin
            match_d = match_q + 4'd1;
          end
          if (match_d == c_lock_frames) begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (w_line_bad || (w_vs_edge && (w_lines != v_total_q))) begin
          state_d     = ST_SEARCH;
          lock_lost_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase
  end

  // Raster counters run freely against the reference; outputs gated by lock
  always_comb begin
    w_x_wrap    = (x_cnt_q == h_total_q - 10'd1);
    w_lock_next = (state_d == ST_LOCKED);
    x_cnt_d     = w_hs_edge ? c_h_load : (w_x_wrap ? 10'd0 : x_cnt_q + 10'd1);
    y_cnt_d     = y_cnt_q;
    if (w_vs_edge) begin
      y_cnt_d = c_v_load;
    end else if (!w_hs_edge && w_x_wrap) begin
      y_cnt_d = (y_cnt_q == v_total_q - 10'd1) ? 10'd0 : y_cnt_q + 10'd1;
    end
    x_pos_d = w_lock_next ? x_cnt_d : 10'd0;
    y_pos_d = w_lock_next ? y_cnt_d : 10'd0;
    de_d    = w_lock_next && (x_cnt_d < c_h_active) && (y_cnt_d < c_v_active);

    w_probe_hit   = (state_q == ST_LOCKED) && (x_pos_q == probe_x) && (y_pos_q == probe_y);
    probe_valid_d = w_probe_hit;
    probe_pix_d   = w_probe_hit ? pix_dly_q : probe_pix_q;
  end

  // State, measurement and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_SEARCH;
      hcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      last_period_q <= 10'd0;
      frame_bad_q   <= 1'b0;
      ref_valid_q   <= 1'b0;
      match_q       <= 4'd0;
      h_total_q     <= 10'd0;
      v_total_q     <= 10'd0;
      lock_lost_q   <= 1'b0;
      x_cnt_q       <= 10'd0;
      y_cnt_q       <= 10'd0;
      x_pos_q       <= 10'd0;
      y_pos_q       <= 10'd0;
      de_q          <= 1'b0;
      probe_pix_q   <= 3'd0;
      probe_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      last_period_q <= last_period_d;
      frame_bad_q   <= frame_bad_d;
      ref_valid_q   <= ref_valid_d;
      match_q       <= match_d;
      h_total_q     <= h_total_d;
      v_total_q     <= v_total_d;
      lock_lost_q   <= lock_lost_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      x_pos_q       <= x_pos_d;
      y_pos_q       <= y_pos_d;
      de_q          <= de_d;
      probe_pix_q   <= probe_pix_d;
      probe_valid_q <= probe_valid_d;
    end
  end

  assign locked      = (state_q == ST_LOCKED);
  assign lock_lost   = lock_lost_q;
  assign x_pos       = x_pos_q;
  assign y_pos       = y_pos_q;
  assign de_out      = de_q;
  assign h_total     = h_total_q;
  assign v_total     = v_total_q;
  assign probe_pix   = probe_pix_q;
  assign probe_valid = probe_valid_q;

`ifdef VGA_DEC_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  // Locked-frame counter wraps; lock-loss counter saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      if ((state_q == ST_LOCKED) && w_vs_edge) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (lock_lost_d && (err_cnt_q != 8'd255)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule
`default_nettype wire
